pattern_feeder: RTL
===================

Name: pattern_feeder

Overview:
Parametrised successor to the fixed-rate single-byte test feeder. Fills the FT600 TX ring buffer with selectable test patterns (counter, LFSR, walking-ones, alternating) at a runtime-programmable rate, in bursts, with multi-byte words. Reports back-pressure as a level and as a saturating stall count, plus a total-words counter. Sits between the test top level and ft600_mode245 on the clk domain.

Parameters:
TX_BUF_WIDTH, 8, log2 of ring entries; pointer width.
WORD_BYTES, 1, bytes per entry (1 or 2); W = 8*WORD_BYTES bits per entry.
DIV_WIDTH, 16, width of rate_div.
CNT_WIDTH, 16, width of stall_count.
LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
enable  input  1  run/stop.
mode  input  2  0 counter, 1 LFSR, 2 walking-ones, 3 alternating 0x55../0xAA...
rate_div  input  DIV_WIDTH  wait cycles between bursts, minus 1.
burst_len  input  8  words per burst, minus 1.
tx_buf  output  W<<TX_BUF_WIDTH  ring storage; entry i at [i*W +: W].
tx_buf_send  output  TX_BUF_WIDTH  write pointer (next entry to fill).
tx_buf_sent  input  TX_BUF_WIDTH  consumer read pointer.
stalled  output  1  a write was blocked by a full ring this cycle (registered).
stall_count  output  CNT_WIDTH  saturating count of blocked cycles.
words_sent  output  32  total words written, wraps.

Behaviour:
- Reset (synchronous): state IDLE; tx_buf_send=0, stalled=0, stall_count=0, words_sent=0, seq=0, lfsr=LFSR_SEED, div counter=0. tx_buf contents are not reset; only written entries are defined.
- Full: (tx_buf_send+1) mod 2^TX_BUF_WIDTH == tx_buf_sent. Capacity is 2^TX_BUF_WIDTH-1 entries. Empty: equal pointers; the block does not act on empty.
- FSM states: IDLE, WAIT, BURST.
  - IDLE: enable=1 -> WAIT with div counter=0.
  - WAIT: counter increments each cycle. When counter==rate_div, go to BURST with burst index=0 and latch mode and burst_len. rate_div=0 gives one WAIT cycle.
  - BURST, not full: write one word per cycle: tx_buf[tx_buf_send*W +: W] <= value; tx_buf_send <= tx_buf_send+1 (natural wrap); words_sent+1; advance generators; stalled <= 0. After word burst_len+1, go to WAIT with counter=0.
  - BURST, full: no write, pointer and generators hold; stalled <= 1; stall_count+1, saturating at all-ones.
  - stalled <= 0 in IDLE and WAIT.
- enable=0 in any state: next state IDLE. A burst in progress is abandoned, with no write that cycle. The pointer, seq, lfsr and counters hold; the pattern resumes on re-enable.
- Pattern values use the value before the advance, and only write cycles advance the generators. Both seq (W bits, +1 per write, wraps) and lfsr advance on every write regardless of mode.
  - mode0: seq.
  - mode1: low W bits of lfsr. 16-bit Galois LFSR, right shift, taps 16'hB400.
  - mode2: 1 << (seq mod W).
  - mode3: all bytes 8'h55 when seq[0]=0, else 8'hAA.
- Mode and burst_len changes take effect only at the next WAIT->BURST transition.
- A pointer change on tx_buf_sent and a write in the same cycle are legal. Full is evaluated on current registered values.
- Latency: first write 1 (IDLE->WAIT) + rate_div+1 cycles after enable rises.

Test Plan:
1. Reset, enable=1, mode0, rate_div=3, burst_len=0, consumer tracks sent=send. Writes occur every 5 cycles: value 0, 1, 2 … at entries 0, 1, 2. stalled=0 throughout.
2. mode0, rate_div=0, burst_len=7, WORD_BYTES=2. Eight consecutive one-cycle writes, values 0..7. One WAIT cycle follows, then the next burst writes 8..15.
3. TX_BUF_WIDTH=4, tx_buf_sent held at 0, burst_len=255. Writes 15 words, then holds send=15. stalled=1 and stall_count increments each cycle. Releasing sent=1 produces exactly one more write, to entry 15, after which send=0 and the block stalls again.
4. mode1 from reset, WORD_BYTES=1. First words are 8'hE1, 8'h70, then the next LFSR states' low bytes, matching a reference model with seed ACE1 and taps B400.
5. mode2, WORD_BYTES=1, 10 writes: 01, 02, … 80, 01, 02. Then mode3: next words alternate 55/AA starting per seq[0].
6. enable dropped mid-burst (burst_len=7, after word 3). No further writes, state IDLE. Re-enable: the pattern continues from value 4 after rate_div+2 cycles. A rst pulse mid-BURST returns all outputs to their reset values on the next cycle.

Source files
------------

// File: rtl/pattern_feeder.sv
`default_nettype none
// ============================================================================
// pattern_feeder: fills the FT600 TX ring with counter/LFSR/walking/alternating
// test words in rate-controlled bursts.  Rev 1.0
// ============================================================================
module pattern_feeder #(
  parameter int          TX_BUF_WIDTH = 8,
  parameter int          WORD_BYTES   = 1,
  parameter int          DIV_WIDTH    = 16,
  parameter int          CNT_WIDTH    = 16,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic                                               enable,
  input  logic [1:0]                                         mode,
  input  logic [DIV_WIDTH-1:0]                               rate_div,
  input  logic [7:0]                                         burst_len,
  output logic [(8*WORD_BYTES)*(1<<TX_BUF_WIDTH)-1:0]        tx_buf,
  output logic [TX_BUF_WIDTH-1:0]                            tx_buf_send,
  input  logic [TX_BUF_WIDTH-1:0]                            tx_buf_sent,
  output logic                                               stalled,
  output logic [CNT_WIDTH-1:0]                               stall_count,
  output logic [31:0]                                        words_sent
);

  localparam int W     = 8 * WORD_BYTES;
  localparam int DEPTH = 1 << TX_BUF_WIDTH;
  localparam int SH    = $clog2(W);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t                state;
  logic [DIV_WIDTH-1:0]  div_cnt;
  logic [7:0]            burst_idx;
  logic [7:0]            burst_last;
  logic [1:0]            mode_lat;
  logic [W-1:0]          seq;
  logic [15:0]           lfsr;
  logic [W-1:0]          mem [DEPTH];

  logic [TX_BUF_WIDTH-1:0] send_inc;
  logic                    full;
  logic                    do_write;
  logic [15:0]             lfsr_next;
  logic [W-1:0]            pattern;

  assign send_inc  = tx_buf_send + TX_BUF_WIDTH'(1);
  assign full      = (send_inc == tx_buf_sent);
  assign do_write  = enable && (state == BURST) && !full;
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);

  // Pattern uses the generator values before this write's advance.
  always_comb begin
    pattern = seq;
    case (mode_lat)
      2'd0:    pattern = seq;
      2'd1:    pattern = lfsr[W-1:0];
      2'd2:    pattern = W'(1) << seq[SH-1:0];
      default: pattern = {WORD_BYTES{seq[0] ? 8'hAA : 8'h55}};
    endcase
  end

  // Ring storage is deliberately not reset; only written entries are defined.
  always_ff @(posedge clk) begin
    if (!rst && do_write) begin
      mem[tx_buf_send] <= pattern;
    end
  end

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_flat
      assign tx_buf[i*W +: W] = mem[i];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      div_cnt     <= '0;
      burst_idx   <= '0;
      burst_last  <= '0;
      mode_lat    <= '0;
      seq         <= '0;
      lfsr        <= LFSR_SEED;
      tx_buf_send <= '0;
      stalled     <= 1'b0;
      stall_count <= '0;
      words_sent  <= '0;
    end else if (!enable) begin
      state   <= IDLE;
      stalled <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state   <= WAIT;
          div_cnt <= '0;
          stalled <= 1'b0;
        end
        WAIT: begin
          stalled <= 1'b0;
          if (div_cnt == rate_div) begin
            state      <= BURST;
            burst_idx  <= '0;
            burst_last <= burst_len;
            mode_lat   <= mode;
          end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
          end
        end
        BURST: begin
          if (full) begin
            stalled <= 1'b1;
            if (stall_count != {CNT_WIDTH{1'b1}}) begin
              stall_count <= stall_count + CNT_WIDTH'(1);
            end
          end else begin
            stalled     <= 1'b0;
            tx_buf_send <= send_inc;
            words_sent  <= words_sent + 32'd1;
            seq         <= seq + W'(1);
            lfsr        <= lfsr_next;
            if (burst_idx == burst_last) begin
              state   <= WAIT;
              div_cnt <= '0;
            end else begin
              burst_idx <= burst_idx + 8'd1;
            end
          end
        end
        default: begin
          state   <= IDLE;
          stalled <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
